// File: rtl/touch_gesture_gen_if.sv
// Command handshake and emulated-pad signals of the touch gesture generator.
// master = command source (self-test / UART injector), slave = the generator.
interface touch_gesture_gen_if;
  logic       CMD_VALID;
  logic [1:0] CMD_CODE;
  logic       CMD_READY;
  logic       ABORT;
  logic       TOUCH_OUT;
  logic       BUSY;
  logic       DONE;
  logic       CMD_ERR;
  logic [7:0] GEST_CNT;

  modport master (
    output CMD_VALID, CMD_CODE, ABORT,
    input  CMD_READY, TOUCH_OUT, BUSY, DONE, CMD_ERR, GEST_CNT
  );

  modport slave (
    input  CMD_VALID, CMD_CODE, ABORT,
    output CMD_READY, TOUCH_OUT, BUSY, DONE, CMD_ERR, GEST_CNT
  );
endinterface

// File: rtl/touch_gesture_gen.sv
// Turns a one-cycle command into a timed tap / double-tap / long-press pad waveform.
// Runs in the 1 kHz domain: one cycle is one millisecond.
module touch_gesture_gen #(
  parameter int unsigned TAP_MS   = 100,
  parameter int unsigned GAP_MS   = 150,
  parameter int unsigned LONG_MS  = 1200,
  parameter int unsigned QUIET_MS = 700
) (
  input  logic                CLK1K,
  input  logic                RSTN,
  touch_gesture_gen_if.slave  gif
);

  localparam logic [11:0] TapLd   = 12'(TAP_MS - 1);
  localparam logic [11:0] GapLd   = 12'(GAP_MS - 1);
  localparam logic [11:0] LongLd  = 12'(LONG_MS - 1);
  localparam logic [11:0] QuietLd = 12'(QUIET_MS - 1);

  // StDecode is the cycle after acceptance, where the latched code is resolved.
  typedef enum logic [2:0] {
    StIdle, StDecode, StPress1, StGap, StPress2, StQuiet
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  code_q, code_d;
  logic        abort_q, abort_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic        done_d, err_d;
  logic        touch_q, ready_q, busy_q, done_q, err_q;
  logic        cnt_zero;

  assign cnt_zero = (cnt_q == 12'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    abort_d = abort_q;
    gcnt_d  = gcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        cnt_d   = '0;
        if (gif.CMD_VALID && ready_q) begin
          code_d  = gif.CMD_CODE;
          state_d = StDecode;
        end
      end

      StDecode: begin
        case (code_q)
          2'b01, 2'b10: begin
            state_d = StPress1;
            cnt_d   = TapLd;
          end
          2'b11: begin
            state_d = StPress1;
            cnt_d   = LongLd;
          end
          default: begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        endcase
      end

      StPress1, StGap, StPress2: begin
        // Abort beats a press or gap ending on the same edge.
        if (gif.ABORT) begin
          state_d = StQuiet;
          cnt_d   = QuietLd;
          abort_d = 1'b1;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - 12'd1;
        end else if (state_q == StPress1 && code_q == 2'b10) begin
          state_d = StGap;
          cnt_d   = GapLd;
        end else if (state_q == StGap) begin
          state_d = StPress2;
          cnt_d   = TapLd;
        end else begin
          state_d = StQuiet;
          cnt_d   = QuietLd;
        end
      end

      StQuiet: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 12'd1;
        end else begin
          state_d = StIdle;
          if (!abort_q) begin
            done_d = 1'b1;
            gcnt_d = gcnt_q + 8'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      code_q  <= '0;
      abort_q <= 1'b0;
      gcnt_q  <= '0;
      touch_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      abort_q <= abort_d;
      gcnt_q  <= gcnt_d;
      touch_q <= (state_d == StPress1) || (state_d == StPress2);
      ready_q <= (state_d == StIdle);
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign gif.TOUCH_OUT = touch_q;
  assign gif.CMD_READY = ready_q;
  assign gif.BUSY      = busy_q;
  assign gif.DONE      = done_q;
  assign gif.CMD_ERR   = err_q;
  assign gif.GEST_CNT  = gcnt_q;

endmodule
